// File: rtl/bn_param_feeder_if.sv
// Load-stream and accumulator-stream bundle for bn_param_feeder.
interface bn_param_feeder_if #(
   parameter int unsigned WIDTH_D = 29,
   parameter int unsigned WIDTH_A = 10,
   parameter int unsigned WIDTH_B = 10,
   parameter int unsigned ADDR_W  = 6
);
   logic                      i_cfg_start;
   logic                      i_cfg_valid;
   logic                      i_cfg_last;
   logic signed [WIDTH_A-1:0] i_cfg_a;
   logic signed [WIDTH_B-1:0] i_cfg_b;
   logic                      o_cfg_ready;
   logic [ADDR_W:0]           i_ch_num;
   logic                      i_vsync;
   logic                      i_hsync;
   logic                      i_reuse;
   logic                      i_valid;
   logic signed [WIDTH_D-1:0] i_tdata;
   logic                      o_vsync;
   logic                      o_hsync;
   logic                      o_reuse;
   logic                      o_valid;
   logic signed [WIDTH_D-1:0] o_tdata;
   logic signed [WIDTH_A-1:0] o_bn_a;
   logic signed [WIDTH_B-1:0] o_bn_b;
   logic                      o_ready;
   logic                      o_err;

   modport master (
      output i_cfg_start, i_cfg_valid, i_cfg_last, i_cfg_a, i_cfg_b, i_ch_num,
             i_vsync, i_hsync, i_reuse, i_valid, i_tdata,
      input  o_cfg_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata,
             o_bn_a, o_bn_b, o_ready, o_err
   );

   modport slave (
      input  i_cfg_start, i_cfg_valid, i_cfg_last, i_cfg_a, i_cfg_b, i_ch_num,
             i_vsync, i_hsync, i_reuse, i_valid, i_tdata,
      output o_cfg_ready, o_vsync, o_hsync, o_reuse, o_valid, o_tdata,
             o_bn_a, o_bn_b, o_ready, o_err
   );
endinterface

// File: rtl/bn_param_feeder.sv
// Per-channel BN coefficient table: loaded over a beat stream, replayed aligned to the accumulator stream.
// Optional BN_DOUBLE_BUF_EN: shadow/active banks, completed loads swap in on the next i_vsync.
module bn_param_feeder #(
   parameter int unsigned WIDTH_D = 29,
   parameter int unsigned WIDTH_A = 10,
   parameter int unsigned WIDTH_B = 10,
   parameter int unsigned CH_MAX  = 64,
   parameter int unsigned ADDR_W  = 6
) (
   input  logic             i_sclk,
   input  logic             i_rst,
   bn_param_feeder_if.slave bus
);
   localparam logic [ADDR_W:0] CH_MAX_W = (ADDR_W+1)'(CH_MAX);
`ifdef BN_DOUBLE_BUF_EN
   localparam int unsigned MEM_AW = ADDR_W + 1;
`else
   localparam int unsigned MEM_AW = ADDR_W;
`endif
   localparam int unsigned MEM_D = 2**MEM_AW;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_READY = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W:0]           wr_cnt_q, wr_cnt_d;
   logic                      ready_q, ready_d;
   logic                      cfg_ready_q;
   logic                      err_q, err_d;
   logic                      wr_en_c, load_done_c, drop_c;
`ifdef BN_DOUBLE_BUF_EN
   logic                      act_q, act_d;
   logic                      pend_q, pend_d;
`endif
   logic                      sync_c;
   logic [ADDR_W:0]           ch_last_c;
   logic [ADDR_W-1:0]         ch_idx_q, ch_idx_d, rd_idx_c;
   logic [MEM_AW-1:0]         wr_addr_c, rd_addr_c;
   logic signed [WIDTH_A-1:0] mem_a [MEM_D];
   logic signed [WIDTH_B-1:0] mem_b [MEM_D];
   logic                      vsync_q, hsync_q, reuse_q, valid_q;
   logic signed [WIDTH_D-1:0] tdata_q;
   logic signed [WIDTH_A-1:0] bn_a_q;
   logic signed [WIDTH_B-1:0] bn_b_q;

   // Load FSM: next state, write strobe, table-ready and error tracking
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      wr_en_c     = 1'b0;
      load_done_c = 1'b0;
      drop_c      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_cfg_start) begin
               state_d  = ST_LOAD;
               wr_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            if (bus.i_cfg_start) begin
               wr_cnt_d = '0;
            end else if (bus.i_cfg_valid) begin
               if (wr_cnt_q < CH_MAX_W) begin
                  wr_en_c  = 1'b1;
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end else begin
                  drop_c = 1'b1;
               end
               if (bus.i_cfg_last) begin
                  state_d     = ST_READY;
                  load_done_c = 1'b1;
               end
            end
         end
         ST_READY: begin
            if (bus.i_cfg_start) begin
               state_d  = ST_LOAD;
               wr_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef BN_DOUBLE_BUF_EN
      ready_d = ready_q | load_done_c;
      act_d   = act_q;
      pend_d  = pend_q;
      // First table goes live at once; later ones wait for a frame boundary outside a load
      if (load_done_c) begin
         if (!ready_q) act_d = ~act_q;
         else          pend_d = 1'b1;
      end else if (pend_q && bus.i_vsync && (state_q != ST_LOAD)) begin
         act_d  = ~act_q;
         pend_d = 1'b0;
      end
`else
      ready_d = (state_d == ST_READY);
`endif
      err_d = err_q | drop_c | (bus.i_valid & ~ready_q);
   end

   // Channel index: sync clears (priority), valid beats advance and wrap at i_ch_num-1
   assign sync_c    = bus.i_vsync | bus.i_hsync;
   assign ch_last_c = bus.i_ch_num - 1'b1;
   assign rd_idx_c  = sync_c ? '0 : ch_idx_q;

   always_comb begin
      ch_idx_d = ch_idx_q;
      if (sync_c) begin
         ch_idx_d = '0;
      end else if (bus.i_valid) begin
         ch_idx_d = ({1'b0, ch_idx_q} == ch_last_c) ? '0 : ch_idx_q + 1'b1;
      end
   end

`ifdef BN_DOUBLE_BUF_EN
   assign wr_addr_c = {~act_q, wr_cnt_q[ADDR_W-1:0]};
   assign rd_addr_c = {act_q, rd_idx_c};
`else
   assign wr_addr_c = wr_cnt_q[ADDR_W-1:0];
   assign rd_addr_c = rd_idx_c;
`endif

   // Table storage is deliberately outside reset so contents survive i_rst
   always_ff @(posedge i_sclk) begin
      if (wr_en_c) begin
         mem_a[wr_addr_c] <= bus.i_cfg_a;
         mem_b[wr_addr_c] <= bus.i_cfg_b;
      end
   end

   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         wr_cnt_q    <= '0;
         ready_q     <= 1'b0;
         cfg_ready_q <= 1'b0;
         err_q       <= 1'b0;
         ch_idx_q    <= '0;
         vsync_q     <= 1'b0;
         hsync_q     <= 1'b0;
         reuse_q     <= 1'b0;
         valid_q     <= 1'b0;
         tdata_q     <= '0;
         bn_a_q      <= '0;
         bn_b_q      <= '0;
`ifdef BN_DOUBLE_BUF_EN
         act_q       <= 1'b0;
         pend_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         ready_q     <= ready_d;
         cfg_ready_q <= (state_d == ST_LOAD);
         err_q       <= err_d;
         ch_idx_q    <= ch_idx_d;
         vsync_q     <= bus.i_vsync;
         hsync_q     <= bus.i_hsync;
         reuse_q     <= bus.i_reuse;
         valid_q     <= bus.i_valid;
         tdata_q     <= bus.i_tdata;
         bn_a_q      <= ready_q ? mem_a[rd_addr_c] : '0;
         bn_b_q      <= ready_q ? mem_b[rd_addr_c] : '0;
`ifdef BN_DOUBLE_BUF_EN
         act_q       <= act_d;
         pend_q      <= pend_d;
`endif
      end
   end

   assign bus.o_cfg_ready = cfg_ready_q;
   assign bus.o_ready     = ready_q;
   assign bus.o_err       = err_q;
   assign bus.o_vsync     = vsync_q;
   assign bus.o_hsync     = hsync_q;
   assign bus.o_reuse     = reuse_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_tdata     = tdata_q;
   assign bus.o_bn_a      = bn_a_q;
   assign bus.o_bn_b      = bn_b_q;
endmodule

// File: tb/tb_bn_param_feeder.sv
// Scoreboard bench for bn_param_feeder: model predicts each beat's outputs, monitor checks them.
module tb_bn_param_feeder;
   localparam int unsigned WD  = 29;
   localparam int unsigned WA  = 10;
   localparam int unsigned WB  = 10;
   localparam int unsigned CHM = 64;
   localparam int unsigned AW  = 6;

   typedef struct packed {
      int                 cy;
      logic signed [WD-1:0] td;
      logic signed [WA-1:0] a;
      logic signed [WB-1:0] b;
      logic               ru;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   exp_t mon_e;

   logic signed [WA-1:0] m_a [2][CHM];
   logic signed [WB-1:0] m_b [2][CHM];
   int   m_act = 0;
   bit   m_pend = 1'b0;
   bit   m_ready = 1'b0;
   bit   m_err = 1'b0;
   bit   m_load = 1'b0;
   int   m_idx = 0;
   int   ch_num = 4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bn_param_feeder_if #(.WIDTH_D(WD), .WIDTH_A(WA), .WIDTH_B(WB), .ADDR_W(AW)) bus ();

   bn_param_feeder #(.WIDTH_D(WD), .WIDTH_A(WA), .WIDTH_B(WB), .CH_MAX(CHM), .ADDR_W(AW)) dut (
      .i_sclk (clk),
      .i_rst  (rst),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      bus.i_cfg_start = 1'b0;
      bus.i_cfg_valid = 1'b0;
      bus.i_cfg_last  = 1'b0;
      bus.i_cfg_a     = '0;
      bus.i_cfg_b     = '0;
      bus.i_vsync     = 1'b0;
      bus.i_hsync     = 1'b0;
      bus.i_reuse     = 1'b0;
      bus.i_valid     = 1'b0;
      bus.i_tdata     = '0;
   endtask

   task automatic idle();
      clr_inputs();
      step();
   endtask

   // One stream cycle: predict outputs from the model, then advance the model index
   task automatic beat(input bit v, input bit vs, input bit hs, input bit ru, input int td);
      exp_t e;
      int   ri;
      bus.i_valid = v;
      bus.i_vsync = vs;
      bus.i_hsync = hs;
      bus.i_reuse = ru;
      bus.i_tdata = WD'(td);
      ri   = (vs || hs) ? 0 : m_idx;
      e.cy = cyc + 1;
      e.td = WD'(td);
      e.ru = ru;
      e.a  = m_ready ? m_a[m_act][ri] : '0;
      e.b  = m_ready ? m_b[m_act][ri] : '0;
      if (v) sbq.push_back(e);
      if (v && !m_ready) m_err = 1'b1;
      if (vs || hs) m_idx = 0;
      else if (v)   m_idx = (m_idx == ch_num - 1) ? 0 : m_idx + 1;
      if (vs && m_pend && !m_load) begin
         m_act  = m_act ^ 1;
         m_pend = 1'b0;
      end
      step();
   endtask

   // kind 0: a=k+1,b=10(k+1); kind 1: a=k-32,b=3k-100; kind 2: a=-5(k+1),b=k+50
   task automatic load(input int n, input int kind, input bit mid_beat);
      int av, bv, wb;
      clr_inputs();
      bus.i_cfg_start = 1'b1;
      step();
      bus.i_cfg_start = 1'b0;
      m_load = 1'b1;
`ifdef BN_DOUBLE_BUF_EN
      wb = m_act ^ 1;
`else
      wb = 0;
      m_ready = 1'b0;
`endif
      chk("ld_cfg_ready", bus.o_cfg_ready, 1);
      chk("ld_ready_start", bus.o_ready, m_ready);
      if (mid_beat) begin
         beat(1'b1, 1'b0, 1'b0, 1'b0, 77);
         clr_inputs();
      end
      for (int k = 0; k < n; k++) begin
         case (kind)
            0:       begin av = k + 1;        bv = 10 * (k + 1); end
            1:       begin av = k - 32;       bv = 3 * k - 100;  end
            default: begin av = -5 * (k + 1); bv = k + 50;       end
         endcase
         chk("ld_busy_ready", bus.o_ready, m_ready);
         bus.i_cfg_valid = 1'b1;
         bus.i_cfg_last  = (k == n - 1);
         bus.i_cfg_a     = WA'(av);
         bus.i_cfg_b     = WB'(bv);
         if (k < CHM) begin
            m_a[wb][k] = WA'(av);
            m_b[wb][k] = WB'(bv);
         end else begin
            m_err = 1'b1;
         end
         step();
      end
      clr_inputs();
      m_load = 1'b0;
`ifdef BN_DOUBLE_BUF_EN
      if (!m_ready) m_act = m_act ^ 1;
      else          m_pend = 1'b1;
`endif
      m_ready = 1'b1;
      chk("ld_done_ready", bus.o_ready, 1);
      chk("ld_done_cfgrdy", bus.o_cfg_ready, 0);
   endtask

   // Every produced beat must match the oldest prediction, on the predicted cycle
   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("sb_extra", sbq.size(), 1);
         end else begin
            mon_e = sbq.pop_front();
            chk("sb_cycle", cyc, mon_e.cy);
            chk("sb_tdata", bus.o_tdata, mon_e.td);
            chk("sb_bn_a", bus.o_bn_a, mon_e.a);
            chk("sb_bn_b", bus.o_bn_b, mon_e.b);
            chk("sb_reuse", bus.o_reuse, mon_e.ru);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      clr_inputs();
      bus.i_ch_num = 7'(ch_num);
      #1 rst = 1'b1;
      repeat (3) step();
      chk("rst_ready", bus.o_ready, 0);
      chk("rst_err", bus.o_err, 0);
      chk("rst_cfgrdy", bus.o_cfg_ready, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_tdata", bus.o_tdata, 0);
      chk("rst_bn_a", bus.o_bn_a, 0);
      rst = 1'b0;
      step();
      chk("idle_cfgrdy", bus.o_cfg_ready, 0);

      // Stream before any table exists
      beat(1'b1, 1'b0, 1'b0, 1'b0, 5);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 6);
      beat(1'b1, 1'b0, 1'b0, 1'b1, 7);
      idle();
      chk("preload_err", bus.o_err, m_err);
      idle();
      chk("err_sticky", bus.o_err, 1);

      // Four-channel table, one frame of eight beats
      load(4, 0, 1'b0);
      chk("err_after_load", bus.o_err, 1);
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("o_vsync", bus.o_vsync, 1);
      for (int i = 0; i < 8; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 100 + i);
      chk("o_vsync_low", bus.o_vsync, 0);
      idle();

      // hsync after beat 2 restarts the channel index; reuse leaves it alone
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 200);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 201);
      beat(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("o_hsync", bus.o_hsync, 1);
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0, (i == 1), 202 + i);
      idle();

      // Reset mid-stream: outputs and flags clear, table storage kept
      bus.i_valid = 1'b1;
      bus.i_tdata = WD'(999);
      rst = 1'b1;
      #2;
      chk("mrst_valid", bus.o_valid, 0);
      chk("mrst_tdata", bus.o_tdata, 0);
      chk("mrst_bn_b", bus.o_bn_b, 0);
      step();
      chk("mrst_ready", bus.o_ready, 0);
      chk("mrst_err", bus.o_err, 0);
      rst = 1'b0;
      m_ready = 1'b0; m_err = 1'b0; m_idx = 0; m_act = 0; m_pend = 1'b0;
      idle();
      chk("post_rst_err", bus.o_err, 0);

      // 65-beat load into a 64-entry table: last beat dropped
      load(65, 1, 1'b0);
      chk("ovf_err", bus.o_err, 1);
      ch_num = 64;
      bus.i_ch_num = 7'(ch_num);
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 65; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 1000 + i);
      idle();

      // Reload while READY with a stream beat inside the load window
      ch_num = 4;
      bus.i_ch_num = 7'(ch_num);
      load(4, 0, 1'b1);
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 300 + i);
      idle();

      // New table loaded mid-frame, then a frame boundary
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 400);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 401);
      load(4, 2, 1'b0);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 402);
      beat(1'b1, 1'b0, 1'b0, 1'b0, 403);
      beat(1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0, 1'b0, 410 + i);
      idle();
      idle();
      chk("sb_left", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bn_param_feeder.md
Name: bn_param_feeder

Overview:
- Upstream companion of the batch-normalization stage.
- Accepts a per-channel coefficient table (scale a, bias b) over a simple load stream and stores it in on-chip RAM.
- Replays the table in lock-step with the convolution accumulator stream, so the BN stage receives tdata, sync flags and the matching a/b on the same cycle.
- Channel-interleaved stream: each pixel's channels arrive back-to-back.

Parameters:
- WIDTH_D, 29, accumulator data width passed through.
- WIDTH_A, 10, signed BN scale width.
- WIDTH_B, 10, signed BN bias width.
- CH_MAX, 64, table depth (maximum channels).
- ADDR_W, 6, table address width; CH_MAX must equal 2**ADDR_W.

Ports:
- i_sclk, in, 1, clock.
- i_rst, in, 1, reset. Asynchronous, active-high.
- i_cfg_start, in, 1, pulse: begin a table load.
- i_cfg_valid, in, 1, load beat valid.
- i_cfg_last, in, 1, final load beat.
- i_cfg_a, in, WIDTH_A, scale for the current channel.
- i_cfg_b, in, WIDTH_B, bias for the current channel.
- o_cfg_ready, out, 1, load beat accepted this cycle.
- i_ch_num, in, ADDR_W+1, channels per pixel, 1..CH_MAX.
- i_vsync / i_hsync / i_reuse / i_valid, in, 1 each, stream sidebands.
- i_tdata, in, WIDTH_D signed, accumulator data.
- o_vsync / o_hsync / o_reuse / o_valid, out, 1 each, delayed sidebands.
- o_tdata, out, WIDTH_D signed, delayed data.
- o_bn_a, out, WIDTH_A signed, scale aligned to o_tdata.
- o_bn_b, out, WIDTH_B signed, bias aligned to o_tdata.
- o_ready, out, 1, table loaded and usable.
- o_err, out, 1, sticky protocol error.

Behaviour:
- Reset: all outputs 0. State IDLE. Write pointer and channel index 0.
- State IDLE
  - o_cfg_ready=0.
  - i_cfg_start -> LOAD, write pointer cleared.
- State LOAD
  - o_cfg_ready=1.
  - Each i_cfg_valid writes {a,b} at the write pointer, then the pointer increments.
  - i_cfg_valid with i_cfg_last -> READY, o_ready=1 on the next cycle.
  - A beat arriving after CH_MAX writes is dropped and sets o_err.
  - i_cfg_start inside LOAD restarts the pointer at 0.
- State READY
  - o_cfg_ready=0.
  - i_cfg_start -> LOAD and clears o_ready, in the same cycle in base build.
- Channel index ch_idx
  - i_vsync or i_hsync cycle: cleared to 0. The clear has priority over increment.
  - i_valid and not sync: increments.
  - Wraps to 0 after i_ch_num-1.
  - i_reuse does not alter the index.
- Read and latency
  - RAM read is synchronous at ch_idx, or at 0 on a sync cycle.
  - All stream outputs are registered copies of the inputs delayed exactly 1 cycle, so o_bn_a/o_bn_b align with o_tdata.
- Stream while not READY
  - i_valid forwarded as-is.
  - o_bn_a/o_bn_b forced to 0.
  - o_err set.
- o_err clears only on i_rst.
- Mid-frame i_ch_num changes are undefined; the bench must hold it stable per frame.
- Reset asserted mid-load: the table contents are kept, but o_ready=0 until a new load completes.

Optional Feature:
- Macro: BN_DOUBLE_BUF_EN.
- Defined:
  - Two table banks.
  - Loads always target the shadow bank, and LOAD is allowed while streaming.
  - After a completed load, a pending-swap flag is set. The banks swap on the next i_vsync, and o_ready stays 1 throughout.
  - A second load completing before the swap overwrites the shadow bank; a single swap still occurs.
- Undefined:
  - Single bank.
  - Entering LOAD drops o_ready immediately, and stream beats then raise o_err.

Test Plan:
- Load 4 channels (a=1,2,3,4; b=10,20,30,40), i_ch_num=4, vsync then 8 valid beats tdata=100..107 -> outputs one cycle later with (a,b) = (1,10),(2,20),(3,30),(4,40),(1,10)… and tdata 100..107 unchanged.
- Same table, hsync after beat 2 -> the next valid beat carries a=1,b=10 (index reset).
- Valid beats before any load -> o_bn_a=o_bn_b=0, o_valid follows, o_err=1 and stays 1.
- Load 65 beats with CH_MAX=64 -> entry 63 holds beat 63, beat 64 dropped, o_err=1, READY after i_cfg_last.
- i_rst pulse mid-stream -> all outputs 0 next cycle, o_ready=0, o_err=0.
- (BN_DOUBLE_BUF_EN) table A active, load table B mid-frame -> beats keep A values until the next i_vsync, B values thereafter, o_ready never drops.
